// File: rtl/thumb_pkg.sv
// Shared types and widths for the Thumb instruction fetch unit.
package thumb_pkg;

   localparam int INSTR_W = 16;
   localparam int ADDR_W  = 32;

   // FETCH: a request may issue; WAIT_SPACE: prefetch queue full, no request;
   // DISCARD: the outstanding request was made stale by a branch.
   typedef enum logic [1:0] {
      FETCH      = 2'd0,
      WAIT_SPACE = 2'd1,
      DISCARD    = 2'd2
   } fetch_state_e;

   // One prefetched halfword together with the address it came from.
   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } q_entry_t;

   // Thumb fetch addresses are always halfword aligned.
   function automatic logic [ADDR_W-1:0] halfword_align(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:1], 1'b0};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch queue: push at tail, pop at head, flush empties it.
module fetch_queue
   import thumb_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  q_entry_t         push_data,
   output q_entry_t         head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   q_entry_t         mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
   endfunction

   // Track pointers and occupancy; flush and reset both empty the queue.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Store pushed entries.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset; an entry is only visible once
      // count covers it, so its power-up contents never reach the outputs.
      if (push) mem[wr_ptr] <= push_data;
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/thumb_fetch.sv
// Thumb instruction fetch unit: issues halfword reads, buffers them in a
// prefetch queue and presents them to decode; branches flush and redirect.
// Optional feature: define FETCH_STALL_COUNT_EN to add the stall_count output.
module thumb_fetch
   import thumb_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC    = 32'h0000_0000,
   parameter int                QUEUE_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_ack,
   input  logic [INSTR_W-1:0] mem_rdata,
   input  logic               branch_valid,
   input  logic [ADDR_W-1:0]  branch_target,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready
`ifdef FETCH_STALL_COUNT_EN
   ,
   output logic [31:0]        stall_count
`endif
);

   localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

   fetch_state_e      state;
   logic [ADDR_W-1:0] fetch_pc;    // address of the current / next request
   logic [ADDR_W-1:0] pending_pc;  // redirect target held while discarding
   logic [ADDR_W-1:0] branch_pc;
   logic [CNT_W-1:0]  q_count;
   logic              q_full;
   logic              q_empty;
   q_entry_t          q_head;
   logic              push;
   logic              pop;

   assign branch_pc = halfword_align(branch_target);

   // Only one request is ever outstanding, so a non-full queue always has room
   // for it. In DISCARD the stale request stays up until memory accepts it.
   assign mem_req  = !rst && ((state == DISCARD) || (state == FETCH && !q_full));
   assign mem_addr = fetch_pc;

   // Data returned in a branch cycle or while discarding is dropped; a flush
   // also suppresses any pop so flushed entries are never consumed.
   assign push = mem_req && mem_ack && (state == FETCH) && !branch_valid;
   assign pop  = instr_valid && instr_ready && !branch_valid;

   fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .flush     (branch_valid),
      .push_data ('{instr: mem_rdata, pc: fetch_pc}),
      .head      (q_head),
      .count     (q_count),
      .full      (q_full),
      .empty     (q_empty)
   );

   assign instr_valid = !q_empty;
   assign instr       = instr_valid ? q_head.instr : '0;
   assign instr_pc    = instr_valid ? q_head.pc    : '0;

   // Fetch control FSM: request issue, back-pressure and branch redirection.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FETCH;
         fetch_pc   <= halfword_align(RESET_PC);
         pending_pc <= halfword_align(RESET_PC);
      end else begin
         unique case (state)
            FETCH: begin
               if (branch_valid) begin
                  if (mem_req && !mem_ack) begin
                     state      <= DISCARD;
                     pending_pc <= branch_pc;
                  end else begin
                     fetch_pc <= branch_pc;
                  end
               end else if (push) begin
                  fetch_pc <= fetch_pc + ADDR_W'(2);
                  if (!pop && q_count == CNT_W'(QUEUE_DEPTH - 1)) state <= WAIT_SPACE;
               end
            end
            WAIT_SPACE: begin
               if (branch_valid) begin
                  fetch_pc <= branch_pc;
                  state    <= FETCH;
               end else if (pop) begin
                  state <= FETCH;
               end
            end
            DISCARD: begin
               if (branch_valid) pending_pc <= branch_pc;
               if (mem_ack) begin
                  fetch_pc <= branch_valid ? branch_pc : pending_pc;
                  state    <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

`ifdef FETCH_STALL_COUNT_EN
   // Count cycles in which decode has nothing to consume; saturates.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count <= '0;
      end else if (!instr_valid && stall_count != 32'hFFFF_FFFF) begin
         stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule
